// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word requests over a request/grant bus
// with in-order responses, and buffers {pc, instr} pairs in a small FIFO for decode.
module fetch_unit #(
    parameter int              DW       = 32,
    parameter logic [DW-1:0]   RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req_o,
    output logic [DW-1:0] imem_addr_o,
    input  logic          imem_gnt_i,
    input  logic          imem_rvalid_i,
    input  logic [DW-1:0] imem_rdata_i,
    input  logic          redirect_i,
    input  logic [DW-1:0] redirect_pc_i,
    output logic          instr_valid_o,
    output logic [DW-1:0] instr_o,
    output logic [DW-1:0] instr_pc_o,
    input  logic          instr_ready_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] fetch_pc_q, fetch_pc_d;
    logic [DW-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;

    logic [DW-1:0] fifo_pc_q    [DEPTH];
    logic [DW-1:0] fifo_instr_q [DEPTH];

    logic [CW:0]   credit_used;
    logic [DW-1:0] redirect_pc_aligned;
    logic          grant;
    logic          resp;
    logic          push;
    logic          pop;

    assign redirect_pc_aligned = redirect_pc_i & ~DW'(3);

    // Credit counts buffered plus in-flight words from registered state only, so a pop
    // this cycle frees its slot for a request next cycle and the FIFO can never overflow.
    assign credit_used = {1'b0, count_q} + {1'b0, outstanding_q};
    assign imem_req_o  = rst & ~redirect_i & (credit_used < (CW+1)'(DEPTH));
    assign imem_addr_o = rst ? fetch_pc_q : RESET_PC;

    assign instr_valid_o = rst & (count_q != '0);
    assign instr_o       = instr_valid_o ? fifo_instr_q[rd_ptr_q] : '0;
    assign instr_pc_o    = instr_valid_o ? fifo_pc_q[rd_ptr_q]    : '0;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        push          = 1'b0;

        grant = imem_req_o & imem_gnt_i;
        resp  = imem_rvalid_i & (outstanding_q != '0);
        pop   = instr_valid_o & instr_ready_i & ~redirect_i;

        if (redirect_i) begin
            // Everything still in flight after this cycle's response becomes stale.
            fetch_pc_d    = redirect_pc_aligned;
            resp_pc_d     = redirect_pc_aligned;
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            outstanding_d = outstanding_q - CW'(resp);
            discard_d     = outstanding_q - CW'(resp);
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + DW'(4);
            end
            if (resp) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + DW'(4);
                end
            end
            outstanding_d = outstanding_q + CW'(grant) - CW'(resp);
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // NOTE: FIFO storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push && rst) begin
            fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a request-level reference model (pending-request queue
// with per-request drop flags and a {pc, instr} queue) is compared against the DUT every cycle.
module tb_fetch_unit;

    localparam int          DW       = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;

    always #5 clk = ~clk;

    fetch_unit #(.DW(DW), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        logic [31:0] pc;
        int          due;
        bit          drop;
    } req_t;

    entry_t      fifo_m[$];
    req_t        pend[$];
    logic [31:0] fpc_m;
    int          cyc;
    int          errors;
    int          checks;
    string       phase;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs (memory answers from the pending queue), check outputs
    // against the model, then advance the model by the rules of the fetch stage.
    task automatic cycle(input bit rst_v, input bit gnt_v, input bit ready_v,
                         input bit redir_v, input logic [31:0] redir_pc,
                         input int lat, input bit jitter, input bit spurious);
        bit          rv;
        logic [31:0] rd;
        bit          req_e;
        bit          valid_e;
        req_t        r;
        entry_t      e;

        @(negedge clk);
        if (!rst_v) pend.delete();
        rst           = rst_v;
        imem_gnt_i    = gnt_v;
        instr_ready_i = ready_v;
        redirect_i    = redir_v;
        redirect_pc_i = redir_pc;
        rv = 1'b0;
        rd = $urandom;
        if (pend.size() > 0 && pend[0].due <= cyc && (!jitter || $urandom_range(0, 2) != 0)) begin
            rv = 1'b1;
            rd = imem_word(pend[0].pc);
        end else if (spurious && pend.size() == 0) begin
            rv = 1'b1;
        end
        imem_rvalid_i = rv;
        imem_rdata_i  = rd;
        #1;

        req_e   = rst_v && !redir_v && (fifo_m.size() + pend.size() < DEPTH);
        valid_e = rst_v && (fifo_m.size() > 0);
        check({phase, ":req"},   32'(imem_req_o),    32'(req_e));
        check({phase, ":addr"},  imem_addr_o,        rst_v ? fpc_m : RESET_PC);
        check({phase, ":valid"}, 32'(instr_valid_o), 32'(valid_e));
        if (valid_e) begin
            check({phase, ":instr"}, instr_o,    fifo_m[0].instr);
            check({phase, ":pc"},    instr_pc_o, fifo_m[0].pc);
        end else if (!rst_v) begin
            check({phase, ":instr_rst"}, instr_o,    32'h0);
            check({phase, ":pc_rst"},    instr_pc_o, 32'h0);
        end

        if (!rst_v) begin
            fifo_m.delete();
            pend.delete();
            fpc_m = RESET_PC;
        end else if (redir_v) begin
            if (rv && pend.size() > 0) void'(pend.pop_front());
            foreach (pend[i]) pend[i].drop = 1'b1;
            fifo_m.delete();
            fpc_m = redir_pc & ~32'h3;
        end else begin
            if (valid_e && ready_v) void'(fifo_m.pop_front());
            if (rv && pend.size() > 0) begin
                r = pend.pop_front();
                if (!r.drop) begin
                    e.pc    = r.pc;
                    e.instr = rd;
                    fifo_m.push_back(e);
                end
            end
            if (req_e && gnt_v) begin
                r.pc   = fpc_m;
                r.due  = cyc + lat;
                r.drop = 1'b0;
                pend.push_back(r);
                fpc_m = fpc_m + 32'd4;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        errors = 0;
        checks = 0;
        cyc    = 0;
        fpc_m  = RESET_PC;
        rst = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
        redirect_i = 1'b0; redirect_pc_i = '0; instr_ready_i = 1'b0;

        phase = "reset";
        repeat (2) cycle(0, 0, 0, 0, 0, 1, 0, 0);

        phase = "stream";
        repeat (12) cycle(1, 1, 1, 0, 0, 1, 0, 0);

        phase = "stall";
        repeat (10) cycle(1, 1, 0, 0, 0, 1, 0, 0);
        phase = "resume";
        repeat (8) cycle(1, 1, 1, 0, 0, 1, 0, 0);

        phase = "nogrant";
        repeat (5) cycle(1, 0, 1, 0, 0, 1, 0, 0);

        phase = "redir_slow";
        repeat (2) cycle(1, 1, 1, 0, 0, 3, 0, 0);
        cycle(1, 1, 1, 1, 32'h103, 3, 0, 0);
        redirect_i = 1'b0;
        #1;
        check("redir_slow:first_addr", imem_addr_o, 32'h100);
        check("redir_slow:first_req", 32'(imem_req_o), 32'h1);
        repeat (12) cycle(1, 1, 1, 0, 0, 3, 0, 0);

        phase = "redir_same";
        repeat (6) cycle(1, 1, 1, 0, 0, 1, 0, 0);
        cycle(1, 1, 1, 1, 32'h200, 1, 0, 0);
        redirect_i = 1'b0;
        #1;
        check("redir_same:fifo_empty", 32'(instr_valid_o), 32'h0);
        repeat (8) cycle(1, 1, 1, 0, 0, 1, 0, 0);

        phase = "midreset";
        repeat (5) cycle(1, 1, 1, 0, 0, 2, 0, 0);
        cycle(0, 1, 1, 0, 0, 1, 0, 0);
        rst = 1'b1;
        #1;
        check("midreset:addr", imem_addr_o, RESET_PC);
        check("midreset:valid", 32'(instr_valid_o), 32'h0);
        phase = "spurious";
        cycle(1, 1, 1, 0, 0, 1, 0, 1);
        repeat (8) cycle(1, 1, 1, 0, 0, 1, 0, 0);

        phase = "wrap";
        cycle(1, 1, 1, 1, 32'hFFFF_FFF9, 1, 0, 0);
        repeat (10) cycle(1, 1, 1, 0, 0, 1, 0, 0);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 29) == 0,
                  $urandom,
                  $urandom_range(1, 3),
                  1'b1,
                  $urandom_range(0, 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
